// File: rtl/wan_seq_arbiter.sv
// rtl/wan_seq_arbiter.sv - round-robin arbiter sharing one WNN sequence-number port among WAN_TX requesters
// Optional response timeout enabled by defining WAN_SEQ_ARB_TIMEOUT_EN.
module wan_seq_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MSG_TYPE_WIDTH = 8,
    parameter int TDEST_WIDTH    = 32,
    parameter int SEQ_WIDTH      = 32,
    parameter int RESP_TIMEOUT   = 64
) (
    input  logic                                r_clk,
    input  logic                                r_resetn,
    input  logic [NUM_REQ-1:0]                  req_tvalid,
    output logic [NUM_REQ-1:0]                  req_tready,
    input  logic [NUM_REQ*MSG_TYPE_WIDTH-1:0]   req_tdata,
    input  logic [NUM_REQ*TDEST_WIDTH-1:0]      req_tdest,
    output logic                                to_WNN_tvalid,
    input  logic                                to_WNN_tready,
    output logic [MSG_TYPE_WIDTH-1:0]           to_WNN_tdata,
    output logic [TDEST_WIDTH-1:0]              to_WNN_tdest,
    input  logic                                from_WNN_tvalid,
    output logic                                from_WNN_tready,
    input  logic [SEQ_WIDTH-1:0]                from_WNN_tdata,
    input  logic [TDEST_WIDTH-1:0]              from_WNN_tdest,
    input  logic                                from_WNN_tuser,
    output logic [NUM_REQ-1:0]                  rsp_tvalid,
    input  logic [NUM_REQ-1:0]                  rsp_tready,
    output logic [SEQ_WIDTH-1:0]                rsp_tdata,
    output logic [TDEST_WIDTH-1:0]              rsp_tdest,
    output logic                                rsp_tuser,
    output logic                                busy,
    output logic [$clog2(NUM_REQ)-1:0]          grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RETURN
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [MSG_TYPE_WIDTH-1:0]   tdata_q, tdata_d;
    logic [TDEST_WIDTH-1:0]      tdest_q, tdest_d;
    logic [SEQ_WIDTH-1:0]        rsp_data_q, rsp_data_d;
    logic                        rsp_user_q, rsp_user_d;

    logic [2*NUM_REQ-1:0]        req_dbl;
    logic [NUM_REQ-1:0]          req_rot;
    logic [IDX_W:0]              sel_sum;
    logic [IDX_W-1:0]            sel_idx;
    logic                        sel_found;
    logic                        rsp_match;

`ifdef WAN_SEQ_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);
    logic [CNT_W-1:0]            cnt_q, cnt_d, cnt_inc;
    logic                        expired;
`endif

    // Rotate the request vector so that bit 0 is rr_ptr, then take the first set bit.
    always_comb begin
        req_dbl   = {req_tvalid, req_tvalid} >> rr_ptr_q;
        req_rot   = req_dbl[NUM_REQ-1:0];
        sel_found = 1'b0;
        sel_sum   = '0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_found && req_rot[k]) begin
                sel_found = 1'b1;
                sel_sum   = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            end
        end
        if (sel_sum >= (IDX_W+1)'(NUM_REQ)) begin
            sel_sum = sel_sum - (IDX_W+1)'(NUM_REQ);
        end
        sel_idx = sel_sum[IDX_W-1:0];
    end

    assign rsp_match = from_WNN_tvalid && (from_WNN_tdest == tdest_q);

`ifdef WAN_SEQ_ARB_TIMEOUT_EN
    assign cnt_inc = (cnt_q == CNT_W'(RESP_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
    assign expired = (cnt_inc == CNT_W'(RESP_TIMEOUT));
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        idx_d      = idx_q;
        tdata_d    = tdata_q;
        tdest_d    = tdest_q;
        rsp_data_d = rsp_data_q;
        rsp_user_d = rsp_user_q;
`ifdef WAN_SEQ_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    idx_d = sel_idx;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (IDX_W'(k) == sel_idx) begin
                            tdata_d = req_tdata[k*MSG_TYPE_WIDTH +: MSG_TYPE_WIDTH];
                            tdest_d = req_tdest[k*TDEST_WIDTH +: TDEST_WIDTH];
                        end
                    end
                    rr_ptr_d = (sel_idx == IDX_W'(NUM_REQ-1)) ? '0 : sel_idx + 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (to_WNN_tready) begin
                    state_d = S_WAIT;
`ifdef WAN_SEQ_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
`ifdef WAN_SEQ_ARB_TIMEOUT_EN
                cnt_d = cnt_inc;
`endif
                // Mismatched responses are accepted (tready high) and simply not captured.
                if (rsp_match) begin
                    rsp_data_d = from_WNN_tdata;
                    rsp_user_d = from_WNN_tuser;
                    state_d    = S_RETURN;
                end
`ifdef WAN_SEQ_ARB_TIMEOUT_EN
                else if (expired) begin
                    rsp_data_d = '0;
                    rsp_user_d = 1'b1;
                    state_d    = S_RETURN;
                end
`endif
            end
            S_RETURN: begin
                if (rsp_tready[idx_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge r_clk or negedge r_resetn) begin
        if (!r_resetn) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            idx_q      <= '0;
            tdata_q    <= '0;
            tdest_q    <= '0;
            rsp_data_q <= '0;
            rsp_user_q <= 1'b0;
`ifdef WAN_SEQ_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            idx_q      <= idx_d;
            tdata_q    <= tdata_d;
            tdest_q    <= tdest_d;
            rsp_data_q <= rsp_data_d;
            rsp_user_q <= rsp_user_d;
`ifdef WAN_SEQ_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // req_tready is gated by reset too, since it follows req_tvalid combinationally.
    always_comb begin
        req_tready = '0;
        rsp_tvalid = '0;
        if (r_resetn && state_q == S_IDLE && sel_found) begin
            req_tready[sel_idx] = 1'b1;
        end
        if (state_q == S_RETURN) begin
            rsp_tvalid[idx_q] = 1'b1;
        end
    end

    assign to_WNN_tvalid   = (state_q == S_ISSUE);
    assign to_WNN_tdata    = tdata_q;
    assign to_WNN_tdest    = tdest_q;
    assign from_WNN_tready = (state_q == S_WAIT);
    assign rsp_tdata       = rsp_data_q;
    assign rsp_tdest       = tdest_q;
    assign rsp_tuser       = rsp_user_q;
    assign busy            = (state_q != S_IDLE);
    assign grant_idx       = idx_q;

endmodule

// File: doc/wan_seq_arbiter.md
WAN_SEQ_ARBITER -- requirements
Module: wan_seq_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of rpn_WAN_TX requesters sharing one WNN sequence-number port (2..8).
REQ-002 The block SHALL have parameter MSG_TYPE_WIDTH, default 8, meaning the RPN message-type width.
REQ-003 The block SHALL have parameter TDEST_WIDTH, default 32, meaning the CTDEST width.
REQ-004 The block SHALL have parameter SEQ_WIDTH, default 32, meaning the WAN sequence-number width.
REQ-005 The block SHALL have parameter RESP_TIMEOUT, default 64, meaning the maximum number of cycles spent waiting for a WNN response.
REQ-006 The block SHALL have port r_clk, input, 1 bit: clock, all logic on the rising edge.
REQ-007 The block SHALL have port r_resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have ports req_tvalid (input, NUM_REQ) and req_tready (output, NUM_REQ): per-requester request handshake.
REQ-009 The block SHALL have port req_tdata, input, NUM_REQ*MSG_TYPE_WIDTH: packed request message types, requester i at slice i.
REQ-010 The block SHALL have port req_tdest, input, NUM_REQ*TDEST_WIDTH: packed request CTDESTs.
REQ-011 The block SHALL have ports to_WNN_tvalid (output, 1), to_WNN_tready (input, 1), to_WNN_tdata (output, MSG_TYPE_WIDTH) and to_WNN_tdest (output, TDEST_WIDTH): the request to the WNN.
REQ-012 The block SHALL have ports from_WNN_tvalid (input, 1), from_WNN_tready (output, 1), from_WNN_tdata (input, SEQ_WIDTH), from_WNN_tdest (input, TDEST_WIDTH) and from_WNN_tuser (input, 1, locked flag): the response from the WNN.
REQ-013 The block SHALL have ports rsp_tvalid (output, NUM_REQ) and rsp_tready (input, NUM_REQ): per-requester response handshake.
REQ-014 The block SHALL have ports rsp_tdata (output, SEQ_WIDTH), rsp_tdest (output, TDEST_WIDTH) and rsp_tuser (output, 1): response payload shared by all requesters, qualified by rsp_tvalid.
REQ-015 The block SHALL have ports busy (output, 1) and grant_idx (output, clog2(NUM_REQ)): status.

Function
REQ-016 The block SHALL use an FSM with states IDLE, ISSUE, WAIT and RETURN, and SHALL keep exactly one transaction outstanding.
REQ-017 In IDLE, when any req_tvalid is high, the block SHALL select the requester round-robin starting at rr_ptr, latch its tdata and tdest and index, pulse req_tready[idx] for 1 cycle, and go to ISSUE; with no request it SHALL stay in IDLE.
REQ-018 rr_ptr SHALL advance to idx+1 (mod NUM_REQ) on each grant.
REQ-019 req_tready SHALL be combinationally 0 in every state other than IDLE.
REQ-020 In ISSUE, to_WNN_tvalid SHALL be 1 with the latched payload, held stable until to_WNN_tready; on the handshake the FSM SHALL go to WAIT and clear the timeout counter.
REQ-021 In WAIT, from_WNN_tready SHALL be 1.
REQ-022 A WAIT response whose from_WNN_tdest equals the latched tdest SHALL be captured into rsp_tdata/rsp_tuser, with the FSM moving to RETURN.
REQ-023 A WAIT response with a mismatched tdest SHALL be consumed and dropped; the FSM SHALL stay in WAIT and the counter SHALL keep counting.
REQ-024 In RETURN, rsp_tvalid[idx] SHALL be the only rsp_tvalid bit set, with rsp_tdest equal to the latched tdest; on rsp_tready[idx] the FSM SHALL return to IDLE.
REQ-025 Grant-to-issue latency SHALL be 1 cycle, and response-to-rsp_tvalid latency SHALL be 1 cycle.
REQ-026 from_WNN_tready SHALL be 0 outside WAIT, so responses arriving outside WAIT are back-pressured, not dropped.
REQ-027 busy SHALL be 1 in every state other than IDLE.
REQ-028 grant_idx SHALL hold the latched index.
REQ-029 The timeout counter SHALL be clog2(RESP_TIMEOUT+1) bits and SHALL saturate, never wrap.

Reset
REQ-030 While r_resetn=0, the block SHALL force state IDLE, rr_ptr=0, latched index/tdata/tdest=0, counter=0, rsp_tdata=0 and rsp_tuser=0.
REQ-031 While r_resetn=0, all outputs SHALL be 0, including to_WNN_tvalid, from_WNN_tready, rsp_tvalid, req_tready, busy and grant_idx.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction without emitting any response.

Configuration
REQ-033 With macro WAN_SEQ_ARB_TIMEOUT_EN defined, the counter SHALL increment every WAIT cycle.
REQ-034 With WAN_SEQ_ARB_TIMEOUT_EN defined, reaching RESP_TIMEOUT with no matching response SHALL force RETURN with rsp_tdata=0 and rsp_tuser=1 (reported as locked).
REQ-035 With WAN_SEQ_ARB_TIMEOUT_EN defined, a matching response in the same cycle as expiry SHALL win.
REQ-036 Without WAN_SEQ_ARB_TIMEOUT_EN, the block SHALL have no counter and WAIT SHALL persist until a matching response arrives.

Verification
REQ-037 The bench SHALL drive req 0 (tdest 0xBCBCBCBC) with WNN replying seq 3300, tuser 0 -> rsp_tvalid[0], rsp_tdata=3300, rsp_tuser=0, rsp_tdest=0xBCBCBCBC.
REQ-038 The bench SHALL hold req 0..3 high continuously -> grant order 0,1,2,3,0, one outstanding transaction, req_tready never high outside IDLE.
REQ-039 The bench SHALL return a WNN response with tdest 0 then 0xBCBCBCBC -> first dropped, second forwarded, exactly one rsp_tvalid.
REQ-040 The bench SHALL, with the macro on and RESP_TIMEOUT=15, never respond -> rsp_tuser=1 and rsp_tdata=0 at WAIT cycle 15; with the macro off, the block SHALL remain in WAIT.
REQ-041 The bench SHALL hold rsp_tready[2]=0 for 20 cycles -> rsp payload stable, from_WNN_tready=0, no new grant.
REQ-042 The bench SHALL assert r_resetn=0 in WAIT -> all outputs 0 at once; after release, a fresh request is granted to requester 0.
